// File: rtl/newton_iter_invsqroot.sv
`default_nettype none
// ============================================================================
// Module   : newton_iter_invsqroot
// Purpose  : Refines an initial inverse-square-root estimate y0 with ITER
//            Newton-Raphson steps y <- y*(1.5 - h*y*y), h = 0.5*x, using a
//            single shared truncating single-precision multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module newton_iter_invsqroot #(
  parameter int ITER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataIn,
  input  logic [31:0] Half_DataIN,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [31:0] DataOut,
  output logic        valid_out,
  input  logic        ready_out
);

  localparam logic [2:0]  ITER_C   = 3'(ITER);
  localparam logic [31:0] C_NAN    = 32'h7FC0_0000;
  localparam logic [31:0] C_INF    = 32'h7F80_0000;
  localparam logic [31:0] C_ONE_P5 = 32'h3FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ   = 3'd1,
    S_MULH = 3'd2,
    S_SUB  = 3'd3,
    S_MULY = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  iter_q, iter_d;
  logic [31:0] y_q, y_d;       // current estimate
  logic [31:0] h_q, h_d;       // 0.5*x
  logic [31:0] t_q, t_d;       // scratch: holds s, then t, then u
  logic [31:0] dout_q, dout_d;

  logic        xfer;
  logic        byp;
  logic [31:0] byp_val;
  logic [2:0]  iter_next;

  logic [31:0] mul_a, mul_b, mul_r;
  logic [47:0] prod;
  logic [9:0]  esum, ebias;

  logic [23:0] sub_al, sub_diff, sub_norm;
  logic [4:0]  sub_msb;
  logic [31:0] sub_r;

  logic        unused_bits;

  assign ready_in  = (state_q == S_IDLE) || ((state_q == S_OUT) && ready_out);
  assign xfer      = valid_in && ready_in;
  assign valid_out = (state_q == S_OUT);
  assign DataOut   = dout_q;
  assign iter_next = {1'b0, iter_q} + 3'd1;

  // Negative h yields NaN; zero/denormal or Inf/NaN h passes y0 straight through.
  assign byp     = Half_DataIN[31] || (Half_DataIN[30:23] == 8'h00) || (Half_DataIN[30:23] == 8'hFF);
  assign byp_val = Half_DataIN[31] ? C_NAN : DataIn;

  // Shared multiplier: y*y in SQ, h*s in MULH, y*u in MULY; operands with a zero exponent are treated as zero.
  always_comb begin
    mul_a = (state_q == S_MULH) ? h_q : y_q;
    mul_b = (state_q == S_SQ)   ? y_q : t_q;
    prod  = 48'({1'b1, mul_a[22:0]}) * 48'({1'b1, mul_b[22:0]});
    esum  = {2'b00, mul_a[30:23]} + {2'b00, mul_b[30:23]} + {9'd0, prod[47]};
    ebias = esum - 10'd127;
    mul_r = 32'h0000_0000;
    if ((mul_a[30:23] == 8'h00) || (mul_b[30:23] == 8'h00) || (esum <= 10'd127)) begin
      mul_r = 32'h0000_0000;
    end else if (ebias >= 10'd255) begin
      mul_r = C_INF;
    end else begin
      mul_r = {mul_a[31] ^ mul_b[31], ebias[7:0], prod[47] ? prod[46:24] : prod[45:23]};
    end
  end

  // u = 1.5 - t with t aligned (truncated) to exponent 127, then renormalised.
  always_comb begin
    sub_al   = {1'b1, t_q[22:0]} >> (8'd127 - t_q[30:23]);
    sub_diff = 24'hC0_0000 - sub_al;
    sub_msb  = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (sub_diff[i]) sub_msb = 5'(i);
    end
    sub_norm = sub_diff << (5'd23 - sub_msb);
    sub_r    = 32'h0000_0000;
    if (t_q[30:23] == 8'h00) begin
      sub_r = C_ONE_P5;
    end else if (t_q[30:23] >= 8'd128) begin
      sub_r = 32'h0000_0000;
    end else if (sub_al >= 24'hC0_0000) begin
      sub_r = 32'h0000_0000;
    end else begin
      sub_r = {1'b0, 8'd104 + {3'b000, sub_msb}, sub_norm[22:0]};
    end
  end

  assign unused_bits = ^{prod[22:0], sub_norm[23], t_q[31]};

  // Next-state and datapath-update logic.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    y_d     = y_q;
    h_d     = h_q;
    t_d     = t_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE, S_OUT: begin
        if ((state_q == S_OUT) && ready_out) state_d = S_IDLE;
        if (xfer) begin
          y_d    = DataIn;
          h_d    = Half_DataIN;
          t_d    = 32'h0000_0000;
          iter_d = 2'd0;
          if (byp) begin
            dout_d  = byp_val;
            state_d = S_OUT;
          end else begin
            state_d = S_SQ;
          end
        end
      end
      S_SQ: begin
        t_d     = mul_r;
        state_d = S_MULH;
      end
      S_MULH: begin
        t_d     = mul_r;
        state_d = S_SUB;
      end
      S_SUB: begin
        t_d     = sub_r;
        state_d = S_MULY;
      end
      S_MULY: begin
        y_d    = mul_r;
        iter_d = iter_next[1:0];
        if (iter_next < ITER_C) begin
          state_d = S_SQ;
        end else begin
          dout_d  = mul_r;
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      iter_q  <= 2'd0;
      y_q     <= 32'h0000_0000;
      h_q     <= 32'h0000_0000;
      t_q     <= 32'h0000_0000;
      dout_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      y_q     <= y_d;
      h_q     <= h_d;
      t_q     <= t_d;
      dout_q  <= dout_d;
    end
  end

endmodule
`default_nettype wire
